// File: rtl/interval_pkg.sv
// Shared types and constants for the interval histogram block.
package interval_pkg;

  typedef enum logic {FP, INT} mode_e;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NUM   = 8;
  localparam int unsigned DEF_CNT_W = 16;

  // IEEE half NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic is_nan_h(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != '0);
  endfunction

endpackage

// File: rtl/interval_ge_cmp.sv
// a >= b under either sign-magnitude float order or two's-complement order.
module interval_ge_cmp
  import interval_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter mode_e       MODE  = FP
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ge_o
);

  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;
  logic             both_zero;

  // Negative floats are bit-inverted so larger magnitudes sort lower; -0/+0 are forced equal.
  always_comb begin
    a_key     = a_i[WIDTH-1] ? ~a_i : {1'b1, a_i[WIDTH-2:0]};
    b_key     = b_i[WIDTH-1] ? ~b_i : {1'b1, b_i[WIDTH-2:0]};
    both_zero = (a_i[WIDTH-2:0] == '0) && (b_i[WIDTH-2:0] == '0);
    if (MODE == INT) ge_o = ($signed(a_i) >= $signed(b_i));
    else             ge_o = both_zero || (a_key >= b_key);
  end

endmodule

// File: rtl/interval_hist.sv
// Classifies a sample stream into NUM intervals via a two-stage pipeline and keeps per-interval counts.
module interval_hist
  import interval_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NUM   = DEF_NUM,
  parameter mode_e       MODE  = FP,
  parameter int unsigned CNT_W = DEF_CNT_W,
  localparam int unsigned IDX_W  = $clog2(NUM),
  localparam int unsigned BIDX_W = (NUM > 2) ? $clog2(NUM-1) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH-1:0]  s_i,
  input  logic              bnd_we_i,
  input  logic [BIDX_W-1:0] bnd_idx_i,
  input  logic [WIDTH-1:0]  bnd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [NUM-1:0]    interval_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              nan_o,
  input  logic              hist_clr_i,
  input  logic [IDX_W-1:0]  hist_sel_i,
  output logic [CNT_W-1:0]  hist_cnt_o
);

  logic [WIDTH-1:0] bnd_q [NUM-1];
  logic [NUM-2:0]   ge;
  logic             sample_nan;

  for (genvar k = 0; k < NUM - 1; k++) begin : g_cmp
    interval_ge_cmp #(.WIDTH(WIDTH), .MODE(MODE)) u_cmp (
      .a_i (s_i),
      .b_i (bnd_q[k]),
      .ge_o(ge[k])
    );
  end

  assign sample_nan = (MODE == FP) && is_nan_h(16'(s_i));

  logic             s1_valid_q;
  logic [NUM-2:0]   s1_ge_q;
  logic             s1_nan_q;
  logic             out_valid_q;
  logic [NUM-1:0]   interval_q;
  logic [IDX_W-1:0] idx_q;
  logic             nan_q;
  logic [CNT_W-1:0] cnt_q [NUM];
  logic [CNT_W-1:0] cnt_d [NUM];
  logic [CNT_W-1:0] hist_q;
  logic [CNT_W-1:0] hist_d;

  logic s2_adv, s1_adv, accept, hs;
  assign s2_adv = !out_valid_q || out_ready_i;
  assign s1_adv = !s1_valid_q || s2_adv;
  assign accept = in_valid_i && s1_adv;
  assign hs     = out_valid_q && out_ready_i;

  logic [NUM:0]     therm;
  logic [NUM-1:0]   interval_d;
  logic [IDX_W-1:0] idx_d;

  // Downward scan leaves the lowest set bit in idx_d, covering non-monotonic boundaries.
  always_comb begin
    therm      = {1'b0, s1_ge_q, 1'b1};
    interval_d = therm[NUM-1:0] ^ therm[NUM:1];
    if (s1_nan_q) interval_d = '0;
    idx_d = '0;
    for (int unsigned k = NUM; k > 0; k--) begin
      if (interval_d[k-1]) idx_d = IDX_W'(k - 1);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM; k++) begin
      cnt_d[k] = cnt_q[k];
      if (hist_clr_i)                                cnt_d[k] = '0;
      else if (hs && interval_q[k] && cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + 1'b1;
    end
    hist_d = (32'(hist_sel_i) < NUM) ? cnt_q[hist_sel_i] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_ge_q     <= '0;
      s1_nan_q    <= 1'b0;
      out_valid_q <= 1'b0;
      interval_q  <= '0;
      idx_q       <= '0;
      nan_q       <= 1'b0;
      hist_q      <= '0;
      for (int unsigned k = 0; k < NUM; k++)     cnt_q[k] <= '0;
      for (int unsigned k = 0; k < NUM - 1; k++) bnd_q[k] <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_ge_q  <= ge;
          s1_nan_q <= sample_nan;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          interval_q <= interval_d;
          idx_q      <= idx_d;
          nan_q      <= s1_nan_q;
        end
      end
      if (bnd_we_i && 32'(bnd_idx_i) < NUM - 1) bnd_q[bnd_idx_i] <= bnd_data_i;
      for (int unsigned k = 0; k < NUM; k++) cnt_q[k] <= cnt_d[k];
      hist_q <= hist_d;
    end
  end

  assign in_ready_o  = s1_adv;
  assign out_valid_o = out_valid_q;
  assign interval_o  = interval_q;
  assign idx_o       = idx_q;
  assign nan_o       = nan_q;
  assign hist_cnt_o  = hist_q;

endmodule

// File: tb/tb_interval_hist.sv
// Scoreboarded bench for interval_hist: FP mode, NUM=8, 4-bit counters.
module tb_interval_hist;
  import interval_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [W-1:0]  s_i = '0;
  logic          bnd_we_i = 1'b0;
  logic [2:0]    bnd_idx_i = '0;
  logic [W-1:0]  bnd_data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [N-1:0]  interval_o;
  logic [2:0]    idx_o;
  logic          nan_o;
  logic          hist_clr_i = 1'b0;
  logic [2:0]    hist_sel_i = '0;
  logic [CW-1:0] hist_cnt_o;

  always #5 clk_i = ~clk_i;

  interval_hist #(.WIDTH(W), .NUM(N), .MODE(FP), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .s_i(s_i),
    .bnd_we_i(bnd_we_i), .bnd_idx_i(bnd_idx_i), .bnd_data_i(bnd_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .interval_o(interval_o), .idx_o(idx_o), .nan_o(nan_o),
    .hist_clr_i(hist_clr_i), .hist_sel_i(hist_sel_i), .hist_cnt_o(hist_cnt_o)
  );

  typedef struct {logic [7:0] iv; logic [2:0] idx; logic nan;} exp_t;
  typedef struct {logic [15:0] s; exp_t e;} vec_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] bnd_m [7];
  int          exp_cnt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] iv, input logic [2:0] idx, input logic nan);
    exp_t e;
    e.iv = iv; e.idx = idx; e.nan = nan;
    return e;
  endfunction

  // Half-precision to real; infinities become +/-1e30.
  function automatic real h2r(input logic [15:0] h);
    int  e;
    int  m;
    real v;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 31) v = 1.0e30;
    else begin
      v = real'(m);
      if (e != 0) v = v + 1024.0;
      else e = 1;
      for (int i = 0; i < 25 - e; i++) v = v / 2.0;
      for (int i = 0; i < e - 25; i++) v = v * 2.0;
    end
    return h[15] ? -v : v;
  endfunction

  function automatic exp_t model(input logic [15:0] s);
    exp_t       e;
    logic [8:0] t;
    real        sv;
    e = mk(8'h00, 3'd0, 1'b0);
    if (s[14:10] == 5'h1F && s[9:0] != 10'd0) begin
      e.nan = 1'b1;
      return e;
    end
    sv = h2r(s);
    t[0] = 1'b1;
    t[8] = 1'b0;
    for (int k = 1; k < 8; k++) t[k] = (sv >= h2r(bnd_m[k-1]));
    for (int k = 0; k < 8; k++) e.iv[k] = t[k] ^ t[k+1];
    for (int k = 7; k >= 0; k--) if (e.iv[k]) e.idx = 3'(k);
    return e;
  endfunction

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  logic       stall_prev = 1'b0;
  logic [7:0] pv_iv;
  logic [2:0] pv_idx;
  logic       pv_nan;
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) stall_prev = 1'b0;
    else begin
      if (out_valid_o && !out_ready_i) begin
        if (stall_prev) begin
          chk("stall_hold_interval", 32'(interval_o), 32'(pv_iv));
          chk("stall_hold_idx", 32'(idx_o), 32'(pv_idx));
          chk("stall_hold_nan", 32'(nan_o), 32'(pv_nan));
        end
        stall_prev = 1'b1;
        pv_iv = interval_o; pv_idx = idx_o; pv_nan = nan_o;
      end else stall_prev = 1'b0;
      if (out_valid_o && out_ready_i) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: got interval 0x%0h with no sample pending", interval_o);
        end else begin
          e = q.pop_front();
          chk("out_interval", 32'(interval_o), 32'(e.iv));
          chk("out_idx", 32'(idx_o), 32'(e.idx));
          chk("out_nan", 32'(nan_o), 32'(e.nan));
          for (int k = 0; k < 8; k++) if (e.iv[k] && exp_cnt[k] < 15) exp_cnt[k]++;
        end
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [15:0] s, input exp_t e);
    int n;
    bit ok;
    n = 0; ok = 1'b0;
    in_valid_i = 1'b1;
    s_i = s;
    while (!ok && n < 50) begin
      @(negedge clk_i);
      ok = in_ready_o;
      @(posedge clk_i); #1;
      n++;
    end
    in_valid_i = 1'b0;
    if (ok) q.push_back(e);
    else begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: sample 0x%0h never accepted", s);
    end
  endtask

  task automatic wr_bnd(input int idx, input logic [15:0] d);
    bnd_we_i = 1'b1; bnd_idx_i = 3'(idx); bnd_data_i = d;
    @(posedge clk_i); #1;
    bnd_we_i = 1'b0;
    bnd_m[idx] = d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  task automatic hist_chk(input int sel, input int exp, input string name);
    hist_sel_i = 3'(sel);
    @(posedge clk_i); #1;
    chk(name, 32'(hist_cnt_o), 32'(exp));
  endtask

  task automatic clr_hist();
    hist_clr_i = 1'b1;
    @(posedge clk_i); #1;
    hist_clr_i = 1'b0;
    for (int k = 0; k < 8; k++) exp_cnt[k] = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        tbl [12];
  logic [15:0] strm [10];
  logic [15:0] init_b [7];

  initial begin
    init_b = '{16'hC400, 16'hC000, 16'hBC00, 16'h0000, 16'h3C00, 16'h4000, 16'h4400};
    strm   = '{16'h3C00, 16'hC400, 16'h4400, 16'h0000, 16'hBC00,
               16'h3800, 16'hC000, 16'h4000, 16'h7C00, 16'hFE00};
    tbl[0]  = '{s: 16'h3C00, e: mk(8'h20, 3'd5, 1'b0)};
    tbl[1]  = '{s: 16'h8000, e: mk(8'h10, 3'd4, 1'b0)};
    tbl[2]  = '{s: 16'hFC00, e: mk(8'h01, 3'd0, 1'b0)};
    tbl[3]  = '{s: 16'h7E00, e: mk(8'h00, 3'd0, 1'b1)};
    tbl[4]  = '{s: 16'hC400, e: mk(8'h02, 3'd1, 1'b0)};
    tbl[5]  = '{s: 16'hC200, e: mk(8'h02, 3'd1, 1'b0)};
    tbl[6]  = '{s: 16'h4400, e: mk(8'h80, 3'd7, 1'b0)};
    tbl[7]  = '{s: 16'h7C00, e: mk(8'h80, 3'd7, 1'b0)};
    tbl[8]  = '{s: 16'h3800, e: mk(8'h10, 3'd4, 1'b0)};
    tbl[9]  = '{s: 16'h4200, e: mk(8'h40, 3'd6, 1'b0)};
    tbl[10] = '{s: 16'hBE00, e: mk(8'h04, 3'd2, 1'b0)};
    tbl[11] = '{s: 16'h0001, e: mk(8'h10, 3'd4, 1'b0)};
    for (int k = 0; k < 7; k++) bnd_m[k] = 16'h0000;
    for (int k = 0; k < 8; k++) exp_cnt[k] = 0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_interval", 32'(interval_o), 32'd0);
    chk("rst_idx", 32'(idx_o), 32'd0);
    chk("rst_nan", 32'(nan_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_hist_cnt", 32'(hist_cnt_o), 32'd0);

    for (int k = 0; k < 7; k++) wr_bnd(k, init_b[k]);

    // Latency: visible two cycles after acceptance
    send(tbl[0].s, tbl[0].e);
    @(negedge clk_i);
    chk("latency_t1_valid", 32'(out_valid_o), 32'd0);
    @(negedge clk_i);
    chk("latency_t2_valid", 32'(out_valid_o), 32'd1);
    @(posedge clk_i); #1;
    drain();

    // Table vectors back to back
    for (int i = 0; i < 12; i++) send(tbl[i].s, tbl[i].e);
    drain();
    for (int k = 0; k < 8; k++) hist_chk(k, exp_cnt[k], $sformatf("hist_after_table_%0d", k));

    // Stream with a 3-cycle output stall
    fork
      begin
        for (int i = 0; i < 10; i++) send(strm[i], model(strm[i]));
      end
      begin
        repeat (4) @(posedge clk_i);
        #1 out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 out_ready_i = 1'b1;
      end
    join
    drain();

    // Boundary write in the acceptance cycle uses the old boundary
    bnd_we_i = 1'b1; bnd_idx_i = 3'd3; bnd_data_i = 16'h4000;
    send(16'h3C00, mk(8'h20, 3'd5, 1'b0));
    bnd_we_i = 1'b0;
    bnd_m[3] = 16'h4000;
    send(16'h3C00, mk(8'h38, 3'd3, 1'b0));
    drain();
    wr_bnd(3, 16'h0000);

    // Saturation with 4-bit counters
    clr_hist();
    for (int i = 0; i < 20; i++) send(16'hBE00, model(16'hBE00));
    drain();
    hist_chk(2, 15, "hist_saturate");
    hist_chk(1, 0, "hist_neighbour_zero");

    // Clear coincident with a handshake wins
    out_ready_i = 1'b0;
    send(16'hBE00, model(16'hBE00));
    repeat (2) @(posedge clk_i);
    #1;
    chk("clr_pre_valid", 32'(out_valid_o), 32'd1);
    hist_clr_i = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    hist_clr_i = 1'b0;
    for (int k = 0; k < 8; k++) exp_cnt[k] = 0;
    drain();
    hist_chk(2, 0, "hist_clr_wins");

    // Reset with two samples in flight
    for (int i = 0; i < 3; i++) send(strm[i], model(strm[i]));
    drain();
    out_ready_i = 1'b0;
    send(16'h3C00, model(16'h3C00));
    send(16'hC400, model(16'hC400));
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_interval", 32'(interval_o), 32'd0);
    chk("midrst_hist_cnt", 32'(hist_cnt_o), 32'd0);
    q.delete();
    for (int k = 0; k < 8; k++) exp_cnt[k] = 0;
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) hist_chk(k, 0, $sformatf("midrst_cnt_%0d", k));
    chk("midrst_no_output", 32'(out_valid_o), 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
